alu_ex_stage: RTL and testbench
===============================

# alu_ex_stage

Execute stage wrapped around the one-hot ALU. Accepts a decoded instruction over a valid/ready handshake, selects operands (register, PC or immediate), evaluates it in an internal ALU instance, and registers the result for the writeback stage. A 2-entry output buffer (main + skid) sustains one instruction per cycle under backpressure, with a synchronous flush for branch redirects.

## Interface
- WIDTH, 32, datapath width; must be a power of two ≥ 8.
- NR_ALU, 10, one-hot opcode width; bit order add, sub, and, or, xor, sll, srl, sra, slt, sltu (bits 0..9).
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  reset; one clock; reset is synchronous and active-low.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- in_alu_op  in  NR_ALU  one-hot operation.
- in_rs1, in_rs2  in  WIDTH  register operands.
- in_pc, in_imm  in  WIDTH  program counter, sign-extended immediate.
- in_src1_pc  in  1  1: operand 1 = in_pc, 0: in_rs1.
- in_src2_imm  in  1  1: operand 2 = in_imm, 0: in_rs2.
- in_rd  in  5  destination register index.
- in_wen  in  1  destination write enable.
- in_flush  in  1  discard all buffered and incoming work.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts.
- out_result  out  WIDTH  ALU result.
- out_rd  out  5  destination index.
- out_wen  out  1  write enable; forced 0 when out_illegal.
- out_illegal  out  1  opcode was not exactly one-hot.

## Operation
- Accept = in_valid & in_ready; output fire = out_valid & out_ready.
- Operands: op1 = in_src1_pc ? in_pc : in_rs1; op2 = in_src2_imm ? in_imm : in_rs2; computed combinationally in the accept cycle, result captured, never recomputed.
- ALU arithmetic modulo 2^WIDTH; shifts use op2[log2(WIDTH)-1:0] only; sra sign-fills; slt/sltu yield 0 or 1 zero-extended.
- Illegal: in_alu_op zero or multi-hot → captured entry has result 0, out_wen 0, out_illegal 1; still flows through handshake.
- Buffer entries: MAIN (drives outputs) and SKID. States: EMPTY (no entries), ONE (MAIN only), TWO (MAIN+SKID).
- EMPTY: accept → ONE.
- ONE: accept & fire → ONE (MAIN replaced); accept & !fire → TWO (new into SKID); fire & !accept → EMPTY.
- TWO: in_ready=0; fire → ONE (SKID moves to MAIN); else hold.
- in_ready = rstn & (state != TWO); purely from registered state, no combinational path from out_ready.
- Order strictly FIFO; no entry dropped or duplicated.
- Flush: in_flush=1 at an edge → state EMPTY; same-cycle accepted instruction is discarded; a same-cycle fire still counts as consumed downstream.

## Timing
- Latency 1: accepted at edge N → out_valid=1 with its result after edge N.
- Throughput 1/cycle while out_ready=1.
- Outputs hold stable while out_valid=1 & out_ready=0.
- Reset (rstn=0 at edge): state EMPTY; out_valid=0, out_result=0, out_rd=0, out_wen=0, out_illegal=0; in_ready=0 while rstn=0, 1 in first cycle after release.
- Reset mid-operation: all buffered entries lost, no output pulse.
- Flush effect: out_valid=0 the cycle after the flush edge; in_ready=1 same cycle.

## Test plan
- Operand select: in_rs1=5, in_imm=0xFFFFFFFD, src2_imm=1, add → out_result=0x00000002 one cycle later; src1_pc=1, in_pc=0x1000, imm=4, add → 0x1004.
- Op sweep: sra 0x80000000 by 4 → 0xF8000000; srl → 0x08000000; sll 1 by 37 → 0x20; slt 0xFFFFFFFF,1 → 1; sltu → 0; sub 3−5 → 0xFFFFFFFE.
- Backpressure: out_ready=0, three back-to-back in_valid (rd 1,2,3) → first two accepted, in_ready=0 on third; raise out_ready → outputs rd 1,2,3 in order, one per cycle, third accepted when state drops to ONE.
- Streaming: 8 consecutive instructions with out_ready=1 → 8 results on consecutive cycles, in_ready never low.
- Illegal: in_alu_op=0 then 0x003, in_wen=1 → out_illegal=1, out_wen=0, out_result=0 for each.
- Flush/reset: state TWO, assert in_flush with in_valid=1 → next cycle out_valid=0, in_ready=1, no result for any of the three; repeat with rstn=0 instead → all outputs 0.

Source files
------------

// File: rtl/alu_ex_stage.sv
// Execute stage: operand select, one-hot ALU and a two-entry (main + skid) output buffer
// so that one instruction per cycle keeps flowing under backpressure, with a synchronous flush.

module alu_onehot #(
    parameter int WIDTH  = 32,
    parameter int NR_ALU = 10
) (
    input  logic [NR_ALU-1:0] op,
    input  logic [WIDTH-1:0]  op1,
    input  logic [WIDTH-1:0]  op2,
    output logic [WIDTH-1:0]  result,
    output logic              illegal
);
    localparam int SH_W = $clog2(WIDTH);

    logic signed [WIDTH-1:0] op1_s;
    logic signed [WIDTH-1:0] op2_s;
    logic        [SH_W-1:0]  shamt;
    logic                    lt_signed;
    logic                    lt_unsigned;

    function automatic logic is_onehot(input logic [NR_ALU-1:0] v);
        return (v != '0) && ((v & (v - NR_ALU'(1))) == '0);
    endfunction

    assign op1_s       = op1;
    assign op2_s       = op2;
    assign shamt       = op2[SH_W-1:0];
    assign lt_signed   = op1_s < op2_s;
    assign lt_unsigned = op1 < op2;

    always_comb begin
        result  = '0;
        illegal = !is_onehot(op);
        if (!illegal) begin
            case (1'b1)
                op[0]:   result = op1 + op2;
                op[1]:   result = op1 - op2;
                op[2]:   result = op1 & op2;
                op[3]:   result = op1 | op2;
                op[4]:   result = op1 ^ op2;
                op[5]:   result = op1 << shamt;
                op[6]:   result = op1 >> shamt;
                op[7]:   result = op1_s >>> shamt;
                op[8]:   result = {{(WIDTH-1){1'b0}}, lt_signed};
                op[9]:   result = {{(WIDTH-1){1'b0}}, lt_unsigned};
                default: result = '0;
            endcase
        end
    end
endmodule

module alu_ex_stage #(
    parameter int WIDTH  = 32,
    parameter int NR_ALU = 10
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NR_ALU-1:0] in_alu_op,
    input  logic [WIDTH-1:0]  in_rs1,
    input  logic [WIDTH-1:0]  in_rs2,
    input  logic [WIDTH-1:0]  in_pc,
    input  logic [WIDTH-1:0]  in_imm,
    input  logic              in_src1_pc,
    input  logic              in_src2_imm,
    input  logic [4:0]        in_rd,
    input  logic              in_wen,
    input  logic              in_flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_result,
    output logic [4:0]        out_rd,
    output logic              out_wen,
    output logic              out_illegal
);
    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    state_t state;
    state_t state_next;

    logic             accept;
    logic             fire;
    logic             load_main;
    logic             load_skid;
    logic             move_skid;

    logic [WIDTH-1:0] op1_p0;
    logic [WIDTH-1:0] op2_p0;
    logic [WIDTH-1:0] result_p0;
    logic             illegal_p0;
    logic             wen_p0;

    logic [WIDTH-1:0] main_result_p1;
    logic [4:0]       main_rd_p1;
    logic             main_wen_p1;
    logic             main_illegal_p1;
    logic [WIDTH-1:0] skid_result_p1;
    logic [4:0]       skid_rd_p1;
    logic             skid_wen_p1;
    logic             skid_illegal_p1;

    // ready depends only on registered state, never on out_ready
    assign in_ready  = rstn & (state != TWO);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign fire      = out_valid & out_ready;

    // Stage p0: operand select and evaluation in the accept cycle
    assign op1_p0 = in_src1_pc  ? in_pc  : in_rs1;
    assign op2_p0 = in_src2_imm ? in_imm : in_rs2;

    alu_onehot #(
        .WIDTH  (WIDTH),
        .NR_ALU (NR_ALU)
    ) u_alu (
        .op      (in_alu_op),
        .op1     (op1_p0),
        .op2     (op2_p0),
        .result  (result_p0),
        .illegal (illegal_p0)
    );

    assign wen_p0 = in_wen & ~illegal_p0;

    always_comb begin
        state_next = state;
        load_main  = 1'b0;
        load_skid  = 1'b0;
        move_skid  = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next = ONE;
                    load_main  = 1'b1;
                end
            end
            ONE: begin
                if (accept && fire) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    state_next = TWO;
                    load_skid  = 1'b1;
                end else if (fire) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (fire) begin
                    state_next = ONE;
                    move_skid  = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
        // a flushed buffer may still absorb data, but it is never marked valid
        if (in_flush) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Stage p1: main/skid entries; main drives the outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            main_result_p1  <= '0;
            main_rd_p1      <= '0;
            main_wen_p1     <= 1'b0;
            main_illegal_p1 <= 1'b0;
            skid_result_p1  <= '0;
            skid_rd_p1      <= '0;
            skid_wen_p1     <= 1'b0;
            skid_illegal_p1 <= 1'b0;
        end else begin
            if (load_main) begin
                main_result_p1  <= result_p0;
                main_rd_p1      <= in_rd;
                main_wen_p1     <= wen_p0;
                main_illegal_p1 <= illegal_p0;
            end else if (move_skid) begin
                main_result_p1  <= skid_result_p1;
                main_rd_p1      <= skid_rd_p1;
                main_wen_p1     <= skid_wen_p1;
                main_illegal_p1 <= skid_illegal_p1;
            end
            if (load_skid) begin
                skid_result_p1  <= result_p0;
                skid_rd_p1      <= in_rd;
                skid_wen_p1     <= wen_p0;
                skid_illegal_p1 <= illegal_p0;
            end
        end
    end

    assign out_result  = main_result_p1;
    assign out_rd      = main_rd_p1;
    assign out_wen     = main_wen_p1;
    assign out_illegal = main_illegal_p1;
endmodule

// File: tb/tb_alu_ex_stage.sv
// Self-checking bench for alu_ex_stage: vector table, handshake corner sequences and a
// randomized run against a queue-based reference model.

module tb_alu_ex_stage;
    localparam int WIDTH  = 32;
    localparam int NR_ALU = 10;

    localparam logic [9:0] OP_ADD  = 10'h001;
    localparam logic [9:0] OP_SUB  = 10'h002;
    localparam logic [9:0] OP_AND  = 10'h004;
    localparam logic [9:0] OP_OR   = 10'h008;
    localparam logic [9:0] OP_XOR  = 10'h010;
    localparam logic [9:0] OP_SLL  = 10'h020;
    localparam logic [9:0] OP_SRL  = 10'h040;
    localparam logic [9:0] OP_SRA  = 10'h080;
    localparam logic [9:0] OP_SLT  = 10'h100;
    localparam logic [9:0] OP_SLTU = 10'h200;

    logic              clk = 1'b0;
    logic              rstn;
    logic              in_valid;
    logic              in_ready;
    logic [NR_ALU-1:0] in_alu_op;
    logic [WIDTH-1:0]  in_rs1;
    logic [WIDTH-1:0]  in_rs2;
    logic [WIDTH-1:0]  in_pc;
    logic [WIDTH-1:0]  in_imm;
    logic              in_src1_pc;
    logic              in_src2_imm;
    logic [4:0]        in_rd;
    logic              in_wen;
    logic              in_flush;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_result;
    logic [4:0]        out_rd;
    logic              out_wen;
    logic              out_illegal;

    int total = 0;
    int passed = 0;

    alu_ex_stage #(.WIDTH(WIDTH), .NR_ALU(NR_ALU)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_alu_op   (in_alu_op),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_pc       (in_pc),
        .in_imm      (in_imm),
        .in_src1_pc  (in_src1_pc),
        .in_src2_imm (in_src2_imm),
        .in_rd       (in_rd),
        .in_wen      (in_wen),
        .in_flush    (in_flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_wen     (out_wen),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        s1pc;
        logic        s2imm;
        logic [31:0] exp_res;
        logic        exp_ill;
    } vec_t;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
    } exp_t;

    vec_t vec[14];
    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [9:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        in_valid    = 1'b1;
        in_alu_op   = op;
        in_rs1      = a;
        in_rs2      = b;
        in_pc       = 32'h0;
        in_imm      = 32'h0;
        in_src1_pc  = 1'b0;
        in_src2_imm = 1'b0;
        in_rd       = rd;
        in_wen      = 1'b1;
    endtask

    // Reference ALU derived from the operation rules, returns {illegal, result}
    function automatic logic [32:0] ref_alu(input logic [9:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int n = 0;
        int idx = 0;
        logic [31:0] r;
        logic [4:0]  sh;
        for (int i = 0; i < 10; i++) begin
            if (op[i]) begin
                n++;
                idx = i;
            end
        end
        if (n != 1) return {1'b1, 32'h0};
        sh = b[4:0];
        case (idx)
            0: r = a + b;
            1: r = a - b;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = a << sh;
            6: r = a >> sh;
            7: r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            8: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            default: r = (a < b) ? 32'd1 : 32'd0;
        endcase
        return {1'b0, r};
    endfunction

    initial begin
        rstn = 1'b0;
        in_valid = 1'b0; in_alu_op = '0; in_rs1 = '0; in_rs2 = '0; in_pc = '0; in_imm = '0;
        in_src1_pc = 1'b0; in_src2_imm = 1'b0; in_rd = '0; in_wen = 1'b0; in_flush = 1'b0;
        out_ready = 1'b0;

        vec[0]  = '{OP_ADD,  32'h5,         32'h100, 32'h0,    32'hFFFF_FFFD, 1'b0, 1'b1, 32'h2,         1'b0};
        vec[1]  = '{OP_ADD,  32'h77,        32'h0,   32'h1000, 32'h4,         1'b1, 1'b1, 32'h1004,      1'b0};
        vec[2]  = '{OP_SRA,  32'h8000_0000, 32'h4,   32'h0,    32'h0,         1'b0, 1'b0, 32'hF800_0000, 1'b0};
        vec[3]  = '{OP_SRL,  32'h8000_0000, 32'h4,   32'h0,    32'h0,         1'b0, 1'b0, 32'h0800_0000, 1'b0};
        vec[4]  = '{OP_SLL,  32'h1,         32'd37,  32'h0,    32'h0,         1'b0, 1'b0, 32'h20,        1'b0};
        vec[5]  = '{OP_SLT,  32'hFFFF_FFFF, 32'h1,   32'h0,    32'h0,         1'b0, 1'b0, 32'h1,         1'b0};
        vec[6]  = '{OP_SLTU, 32'hFFFF_FFFF, 32'h1,   32'h0,    32'h0,         1'b0, 1'b0, 32'h0,         1'b0};
        vec[7]  = '{OP_SUB,  32'h3,         32'h5,   32'h0,    32'h0,         1'b0, 1'b0, 32'hFFFF_FFFE, 1'b0};
        vec[8]  = '{OP_AND,  32'hF0F0,      32'hFF00, 32'h0,   32'h0,         1'b0, 1'b0, 32'hF000,      1'b0};
        vec[9]  = '{OP_OR,   32'hF0F0,      32'hFF00, 32'h0,   32'h0,         1'b0, 1'b0, 32'hFFF0,      1'b0};
        vec[10] = '{OP_XOR,  32'hF0F0,      32'hFF00, 32'h0,   32'h0,         1'b0, 1'b0, 32'h0FF0,      1'b0};
        vec[11] = '{10'h000, 32'h5,         32'h6,   32'h0,    32'h0,         1'b0, 1'b0, 32'h0,         1'b1};
        vec[12] = '{10'h003, 32'h5,         32'h6,   32'h0,    32'h0,         1'b0, 1'b0, 32'h0,         1'b1};
        vec[13] = '{OP_SRA,  32'h7FFF_FFF0, 32'd36,  32'h0,    32'h0,         1'b0, 1'b0, 32'h07FF_FFFF, 1'b0};

        // reset state
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_out_wen", 32'(out_wen), 32'd0);
        chk("rst_out_illegal", 32'(out_illegal), 32'd0);
        rstn = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // back-to-back vector table with out_ready high
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            in_valid    = 1'b1;
            in_alu_op   = vec[i].op;
            in_rs1      = vec[i].rs1;
            in_rs2      = vec[i].rs2;
            in_pc       = vec[i].pc;
            in_imm      = vec[i].imm;
            in_src1_pc  = vec[i].s1pc;
            in_src2_imm = vec[i].s2imm;
            in_rd       = 5'(i + 1);
            in_wen      = 1'b1;
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_result", i), out_result, vec[i].exp_res);
            chk($sformatf("vec%0d_illegal", i), 32'(out_illegal), 32'(vec[i].exp_ill));
            chk($sformatf("vec%0d_wen", i), 32'(out_wen), 32'(!vec[i].exp_ill));
            chk($sformatf("vec%0d_rd", i), 32'(out_rd), 32'(i + 1));
        end
        in_valid = 1'b0;
        tick();
        chk("vec_drain_valid", 32'(out_valid), 32'd0);

        // backpressure: two accepted, third stalls until an entry drains
        out_ready = 1'b0;
        drive(OP_ADD, 32'd100, 32'd1, 5'd1);
        tick();
        chk("bp1_valid", 32'(out_valid), 32'd1);
        chk("bp1_ready", 32'(in_ready), 32'd1);
        drive(OP_ADD, 32'd100, 32'd2, 5'd2);
        tick();
        chk("bp2_ready", 32'(in_ready), 32'd0);
        chk("bp2_rd", 32'(out_rd), 32'd1);
        drive(OP_ADD, 32'd100, 32'd3, 5'd3);
        tick();
        chk("bp3_ready", 32'(in_ready), 32'd0);
        chk("bp3_hold_rd", 32'(out_rd), 32'd1);
        chk("bp3_hold_result", out_result, 32'd101);
        out_ready = 1'b1;
        tick();
        chk("bp4_rd", 32'(out_rd), 32'd2);
        chk("bp4_result", out_result, 32'd102);
        chk("bp4_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp5_rd", 32'(out_rd), 32'd3);
        chk("bp5_result", out_result, 32'd103);
        chk("bp5_valid", 32'(out_valid), 32'd1);
        tick();
        chk("bp6_valid", 32'(out_valid), 32'd0);

        // flush from the full state with a live incoming instruction
        out_ready = 1'b0;
        drive(OP_ADD, 32'd200, 32'd4, 5'd4);
        tick();
        drive(OP_ADD, 32'd200, 32'd5, 5'd5);
        tick();
        chk("fl_full_ready", 32'(in_ready), 32'd0);
        drive(OP_ADD, 32'd200, 32'd6, 5'd6);
        in_flush = 1'b1;
        tick();
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_ready", 32'(in_ready), 32'd1);
        in_flush  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("fl_after_valid", 32'(out_valid), 32'd0);

        // reset in the middle of a full buffer
        out_ready = 1'b0;
        drive(OP_ADD, 32'd300, 32'd7, 5'd7);
        tick();
        drive(OP_ADD, 32'd300, 32'd8, 5'd8);
        tick();
        drive(OP_ADD, 32'd300, 32'd9, 5'd9);
        rstn = 1'b0;
        tick();
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_result", out_result, 32'd0);
        chk("mrst_rd", 32'(out_rd), 32'd0);
        chk("mrst_wen", 32'(out_wen), 32'd0);
        chk("mrst_illegal", 32'(out_illegal), 32'd0);
        chk("mrst_ready", 32'(in_ready), 32'd0);
        rstn = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("mrst_after_valid", 32'(out_valid), 32'd0);
        chk("mrst_after_ready", 32'(in_ready), 32'd1);

        // randomized traffic against the queue model
        q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic acc;
            logic fr;
            logic [32:0] r;
            logic [31:0] a;
            logic [31:0] b;
            exp_t e;
            chk("rnd_in_ready", 32'(in_ready), 32'(q.size() < 2));
            chk("rnd_out_valid", 32'(out_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("rnd_result", out_result, q[0].result);
                chk("rnd_rd", 32'(out_rd), 32'(q[0].rd));
                chk("rnd_wen", 32'(out_wen), 32'(q[0].wen));
                chk("rnd_illegal", 32'(out_illegal), 32'(q[0].ill));
            end
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            in_flush    = ($urandom_range(0, 29) == 0);
            in_alu_op   = ($urandom_range(0, 7) == 0) ? 10'($urandom)
                                                       : 10'(1 << $urandom_range(0, 9));
            in_rs1      = $urandom;
            in_rs2      = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 70));
            in_pc       = $urandom;
            in_imm      = $urandom;
            in_src1_pc  = 1'($urandom_range(0, 1));
            in_src2_imm = 1'($urandom_range(0, 1));
            in_rd       = 5'($urandom);
            in_wen      = 1'($urandom_range(0, 1));
            a = in_src1_pc ? in_pc : in_rs1;
            b = in_src2_imm ? in_imm : in_rs2;
            r = ref_alu(in_alu_op, a, b);
            e.result = r[31:0];
            e.ill    = r[32];
            e.wen    = in_wen & ~r[32];
            e.rd     = in_rd;
            acc = in_valid && (q.size() < 2);
            fr  = (q.size() != 0) && out_ready;
            tick();
            if (fr) void'(q.pop_front());
            if (in_flush) q.delete();
            else if (acc) q.push_back(e);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
